// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker: locks onto a received LFSR state stream, counts errors, detects loss of lock.
// Optional statistics outputs (word_count, lock_loss_count) are enabled by defining LFSR_CHK_STATS_EN.
module lfsr_checker #(
    parameter int               WIDTH      = 7,
    parameter logic [WIDTH-1:0] TAPS       = 7'b1100000,
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3,
    parameter int               ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
`ifdef LFSR_CHK_STATS_EN
    output logic [31:0]      word_count,
    output logic [7:0]       lock_loss_count,
`endif
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        UNUSED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pred_q, pred_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       run_inc;
    logic             mism;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_count_q;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ^(s & TAPS);
        return {s[WIDTH-2:0], fb};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign run_inc = run_q + 4'd1;

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        run_d   = run_q;
        mism    = 1'b0;
        if (valid_in) begin
            case (state_q)
                SEARCH: begin
                    if (data_in != '0) begin
                        pred_d  = lfsr_next(data_in);
                        run_d   = 4'd0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_in == pred_q) begin
                        pred_d = lfsr_next(data_in);
                        if (run_inc == 4'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        // Reseed from the current word rather than waiting a cycle in SEARCH
                        run_d = 4'd0;
                        if (data_in != '0) begin
                            pred_d  = lfsr_next(data_in);
                            state_d = VERIFY;
                        end else begin
                            state_d = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction advances from itself, never from a bad word
                    pred_d = lfsr_next(pred_q);
                    if (data_in == pred_q) begin
                        run_d = 4'd0;
                    end else begin
                        mism = 1'b1;
                        if (run_inc == 4'(LOSS_COUNT)) begin
                            state_d = SEARCH;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    run_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            pred_q      <= '0;
            run_q       <= 4'd0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            run_q       <= run_d;
            err_pulse_q <= mism;
            if (mism) begin
                err_count_q <= sat_inc_err(err_count_q);
            end
        end
    end

`ifdef LFSR_CHK_STATS_EN
    logic [31:0] word_count_q;
    logic [7:0]  lock_loss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_q <= '0;
            lock_loss_q  <= '0;
        end else begin
            if (valid_in && (state_q == LOCKED) && !(&word_count_q)) begin
                word_count_q <= word_count_q + 32'd1;
            end
            if ((state_q == LOCKED) && (state_d == SEARCH) && !(&lock_loss_q)) begin
                lock_loss_q <= lock_loss_q + 8'd1;
            end
        end
    end

    assign word_count      = word_count_q;
    assign lock_loss_count = lock_loss_q;
`endif

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock acquisition, flywheel error handling, loss of lock, valid gaps, saturation, reset.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  data_in;
    logic        valid_in;

    logic        locked,  err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state_out;

    logic        locked2, err_pulse2;
    logic [1:0]  err_count2;
    logic [1:0]  state_out2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state_out (state_out)
    );

    // Narrow error counter instance shares the stimulus to exercise saturation
    lfsr_checker #(.ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2),
        .state_out (state_out2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic [6:0] d, input logic v);
        data_in  = d;
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        data_in = '0;
        valid_in = 1'b0;
        cyc(7'h00, 1'b0);
        cyc(7'h00, 1'b0);
        rst = 1'b0;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        chk("rst_pulse", 32'(err_pulse), 0);
        chk("rst_state", 32'(state_out), 0);

        // Acquire lock: 01 seeds, 02/04/08/10 are the four correct predictions
        cyc(7'h01, 1'b1); chk("seed_state", 32'(state_out), 1);
        cyc(7'h02, 1'b1); chk("v1_locked", 32'(locked), 0);
        cyc(7'h04, 1'b1); chk("v2_state", 32'(state_out), 1);
        cyc(7'h08, 1'b1); chk("v3_locked", 32'(locked), 0);
        cyc(7'h10, 1'b1); chk("lock_locked", 32'(locked), 1);
        chk("lock_state", 32'(state_out), 2);
        cyc(7'h20, 1'b1); chk("l20_pulse", 32'(err_pulse), 0);
        chk("l20_errcnt", 32'(err_count), 0);

        // Single corrupted word in place of 0x41; flywheel still predicts 0x03 next
        cyc(7'h00, 1'b1); chk("bad1_pulse", 32'(err_pulse), 1);
        chk("bad1_errcnt", 32'(err_count), 1);
        chk("bad1_locked", 32'(locked), 1);
        cyc(7'h03, 1'b1); chk("fly03_pulse", 32'(err_pulse), 0);
        chk("fly03_errcnt", 32'(err_count), 1);
        cyc(7'h06, 1'b1); chk("fly06_pulse", 32'(err_pulse), 0);

        // Idle cycle while locked holds everything
        cyc(7'h55, 1'b0); chk("gap_pulse", 32'(err_pulse), 0);
        chk("gap_errcnt", 32'(err_count), 1);

        // Three consecutive wrong words (expected 0C,18,30) drop lock
        cyc(7'h7F, 1'b1); chk("w1_errcnt", 32'(err_count), 2);
        chk("w1_locked", 32'(locked), 1);
        cyc(7'h7F, 1'b1); chk("w2_errcnt", 32'(err_count), 3);
        chk("w2_sat_cnt", 32'(err_count2), 3);
        cyc(7'h7F, 1'b1); chk("w3_errcnt", 32'(err_count), 4);
        chk("w3_locked", 32'(locked), 0);
        chk("w3_state", 32'(state_out), 0);
        chk("w3_sat_cnt", 32'(err_count2), 3);
        chk("w3_sat_pulse", 32'(err_pulse2), 1);

        // Mismatches outside LOCKED never count
        cyc(7'h00, 1'b1); chk("srch_pulse", 32'(err_pulse), 0);
        chk("srch_errcnt", 32'(err_count), 4);

        // Reset clears counters; all-zero stream stays in SEARCH
        rst = 1'b1;
        cyc(7'h00, 1'b0);
        rst = 1'b0;
        chk("rst2_errcnt", 32'(err_count), 0);
        chk("rst2_sat_cnt", 32'(err_count2), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(7'h00, 1'b1);
            chk("zero_state", 32'(state_out), 0);
            chk("zero_locked", 32'(locked), 0);
        end
        chk("zero_errcnt", 32'(err_count), 0);

        // VERIFY with a zero word returns to SEARCH
        cyc(7'h41, 1'b1); chk("seed41_state", 32'(state_out), 1);
        cyc(7'h00, 1'b1); chk("vzero_state", 32'(state_out), 0);

        // Lock with valid gaps: seed 03, then matches 06,0C,18,30 interleaved with idle cycles
        cyc(7'h03, 1'b1); chk("gseed_state", 32'(state_out), 1);
        cyc(7'h06, 1'b0); chk("g0_state", 32'(state_out), 1);
        cyc(7'h06, 1'b1);
        cyc(7'h2A, 1'b0); chk("g1_state", 32'(state_out), 1);
        cyc(7'h0C, 1'b1);
        cyc(7'h00, 1'b0); chk("g2_state", 32'(state_out), 1);
        cyc(7'h18, 1'b1); chk("g3_locked", 32'(locked), 0);
        cyc(7'h30, 1'b0); chk("g3i_locked", 32'(locked), 0);
        chk("g3i_state", 32'(state_out), 1);
        cyc(7'h30, 1'b1); chk("g4_locked", 32'(locked), 1);
        cyc(7'h61, 1'b1); chk("g61_pulse", 32'(err_pulse), 0);
        chk("g61_locked", 32'(locked), 1);
        cyc(7'h42, 1'b1); chk("g42_errcnt", 32'(err_count), 0);

        // Bad word and reset in the same cycle: reset wins
        cyc(7'h00, 1'b1); chk("pre_rst_errcnt", 32'(err_count), 1);
        rst = 1'b1;
        cyc(7'h00, 1'b1);
        rst = 1'b0;
        chk("rst3_locked", 32'(locked), 0);
        chk("rst3_pulse", 32'(err_pulse), 0);
        chk("rst3_errcnt", 32'(err_count), 0);
        chk("rst3_state", 32'(state_out), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
